// File: rtl/iter_mul_ctrl.sv
// iter_mul_ctrl: iterative unsigned multiplier using a carry-save accumulator and one final add
// Define ITER_MUL_EARLY_TERM_EN to end compression once no set multiplier bits remain.
module iter_mul_ctrl #(
  parameter int size = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              kill,
  input  logic [size-1:0]   a,
  input  logic [size-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*size-1:0] product
);
  localparam int CW = size > 1 ? $clog2(size) : 1;
  typedef enum logic [1:0] {IDLE, COMPRESS, RESOLVE, DONE} state_t;
  state_t            state, state_nx;
  logic [size-1:0]   a_q, b_q;
  logic [2*size-1:0] sum, carry, pp;
  logic [CW-1:0]     count;
  logic              accept, last;
  assign accept = (state == IDLE || state == DONE) && start && !kill;
  assign pp     = b_q[count] ? {{size{1'b0}}, a_q} << count : '0;
`ifdef ITER_MUL_EARLY_TERM_EN
  assign last   = count == CW'(size - 1) || ((b_q >> count) >> 1) == '0;
`else
  assign last   = count == CW'(size - 1);
`endif
  assign busy   = state == COMPRESS || state == RESOLVE;
  assign done   = state == DONE;
  always_comb begin
    state_nx = kill ? IDLE :
               accept ? COMPRESS :
               state == COMPRESS ? (last ? RESOLVE : COMPRESS) :
               state == RESOLVE ? DONE : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end
  // sum/carry form a redundant accumulator; only RESOLVE pays for carry propagation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      sum     <= '0;
      carry   <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        sum   <= '0;
        carry <= '0;
        count <= '0;
      end else if (state == COMPRESS && !kill) begin
        sum   <= sum ^ carry ^ pp;
        carry <= ((sum & carry) | (sum & pp) | (carry & pp)) << 1;
        count <= count + 1'b1;
      end
      if (state == RESOLVE && !kill) product <= sum + carry;
    end
  end
endmodule

// File: tb/tb_iter_mul_ctrl.sv
// tb_iter_mul_ctrl: cycle-accurate reference-model bench for iter_mul_ctrl
module tb_iter_mul_ctrl;
  logic        clk, reset, start, kill;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] product;
  int          checks = 0, failures = 0;
  int          mk, ml;
  logic [31:0] ma, mb;
  logic [63:0] mprod;

  iter_mul_ctrl #(.size(32)) dut (
    .clk(clk), .reset(reset), .start(start), .kill(kill),
    .a(a), .b(b), .busy(busy), .done(done), .product(product)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // compression length in cycles for a given multiplier
  function automatic int clen(input logic [31:0] bv);
`ifdef ITER_MUL_EARLY_TERM_EN
    for (int i = 31; i >= 0; i--) if (bv[i]) return i + 1;
    return 1;
`else
    return 32;
`endif
  endfunction

  // mk = cycles since acceptance (0 = nothing in flight); done arrives at mk == ml+2
  task automatic model_step(input logic s, input logic kl, input logic [31:0] av, input logic [31:0] bv);
    if (kl) mk = 0;
    else if ((mk == 0 || mk == ml + 2) && s) begin
      ma = av; mb = bv; ml = clen(bv); mk = 1;
    end
    else if (mk == ml + 2) mk = 0;
    else if (mk > 0) mk++;
    if (mk == ml + 2) mprod = {32'b0, ma} * {32'b0, mb};
  endtask

  task automatic compare_outputs;
    check("busy", busy, mk >= 1 && mk <= ml + 1);
    check("done", done, mk == ml + 2);
    check("product", product, mprod);
  endtask

  task automatic cyc(input logic s, input logic kl, input logic [31:0] av, input logic [31:0] bv);
    start = s; kill = kl; a = av; b = bv;
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_step(s, kl, av, bv);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, $urandom, $urandom);
  endtask

  task automatic to_done;
    int guard = 0;
    while (mk != ml + 2 && guard < 60) begin
      cyc(0, 0, $urandom, $urandom);
      guard++;
    end
    check("reach_done", mk == ml + 2, 1);
  endtask

  task automatic mid_reset;
    #3 reset = 1;
    start = 0; kill = 0;
    mk = 0; mprod = 0;
    @(negedge clk);
    compare_outputs();
    check("rst_busy0", busy, 0);
    check("rst_prod0", product, 0);
    @(posedge clk);
    #1 reset = 0;
  endtask

  initial begin
    reset = 1; start = 0; kill = 0; a = 0; b = 0;
    mk = 0; ml = 32; ma = 0; mb = 0; mprod = 0;
    @(negedge clk);
    compare_outputs();
    check("reset_done", done, 0);
    check("reset_product", product, 0);
    @(posedge clk);
    #1 reset = 0;
    // 3*5 immediately after reset release
    cyc(1, 0, 32'd3, 32'd5);
    to_done();
    check("p15_dut", product, 64'd15);
    idle(2);
    // all-ones operands
    cyc(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    to_done();
    check("p_max", product, 64'hFFFF_FFFE_0000_0001);
    idle(1);
    // start while busy ignored, back-to-back start in DONE
    cyc(1, 0, 32'd3, 32'd5);
    idle(9);
    cyc(1, 0, 32'd7, 32'd7);
    to_done();
    check("ignored_start", product, 64'd15);
    cyc(1, 0, 32'd7, 32'd7);
    to_done();
    check("p49", product, 64'd49);
    idle(1);
    // kill mid-operation keeps the previous product
    cyc(1, 0, 32'd2, 32'd2);
    to_done();
    idle(1);
    cyc(1, 0, 32'd2, 32'd3);
    idle(3);
    cyc(0, 1, 32'd0, 32'd0);
    idle(3);
    check("kill_hold", product, 64'd4);
    // kill wins over simultaneous start
    cyc(1, 1, 32'd9, 32'd9);
    idle(2);
    // async reset mid-operation
    cyc(1, 0, 32'd11, 32'd13);
    idle(6);
    mid_reset();
    idle(40);
    // early-termination style operands and zero
    cyc(1, 0, 32'd6, 32'd5);
    to_done();
    cyc(1, 0, 32'd6, 32'd0);
    to_done();
    check("p_zero", product, 64'd0);
    idle(1);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] rb;
      rb = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 255)) : $urandom;
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0, $urandom, rb);
    end
    idle(40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/iter_mul_ctrl.md
ITER_MUL_CTRL -- requirements
Module: iter_mul_ctrl

Interface
REQ-001 The block SHALL have parameter: size, 32, operand width in bits (product width 2*size).
REQ-002 The block SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port: start  input  1  request to begin an unsigned multiply.
REQ-005 The block SHALL have port: kill  input  1  synchronous abort of the operation in flight.
REQ-006 The block SHALL have port: a  input  size  multiplicand, sampled on acceptance.
REQ-007 The block SHALL have port: b  input  size  multiplier, sampled on acceptance.
REQ-008 The block SHALL have port: busy  output  1  high while an operation is in flight.
REQ-009 The block SHALL have port: done  output  1  single-cycle pulse marking product valid.
REQ-010 The block SHALL have port: product  output  2*size  registered unsigned result a*b.

Function
REQ-011 The block SHALL implement a state machine with states IDLE, COMPRESS, RESOLVE, DONE.
REQ-012 The block SHALL accept start only in IDLE or DONE with kill low, latching a, b and clearing the redundant accumulator (sum, carry) and bit counter to 0, then entering COMPRESS.
REQ-013 The block SHALL ignore start in COMPRESS and RESOLVE, with no change to latched operands.
REQ-014 Each COMPRESS cycle SHALL form pp = latched b bit[count] ? (a << count) : 0 at 2*size bits, and update sum <= sum^carry^pp, carry <= majority(sum,carry,pp) << 1, discarding bit 2*size.
REQ-015 COMPRESS SHALL exit to RESOLVE after the cycle with count = size-1 (size COMPRESS cycles), count incrementing by 1 per cycle.
REQ-016 RESOLVE SHALL last one cycle and register product <= sum + carry (2*size-bit carry-propagate add, overflow discarded), then enter DONE.
REQ-017 DONE SHALL last one cycle with done = 1, then enter IDLE, or COMPRESS if start is accepted that cycle.
REQ-018 busy SHALL be 1 exactly in COMPRESS and RESOLVE; done SHALL be 1 exactly in DONE; both decoded from state.
REQ-019 Latency: start accepted at end of cycle 0 SHALL give done = 1 in cycle size+2 (cycle 34 for size = 32).
REQ-020 product SHALL hold its value from RESOLVE until the next RESOLVE, including through kill and IDLE.
REQ-021 kill high in any state SHALL force IDLE at the next edge with no done pulse; kill SHALL take priority over a simultaneous start.

Reset
REQ-022 reset SHALL asynchronously force state IDLE and busy, done, product, sum, carry, count and latched operands to 0.
REQ-023 reset asserted mid-operation SHALL discard the operation; no done SHALL follow reset release.
REQ-024 The first start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-025 With macro ITER_MUL_EARLY_TERM_EN defined, COMPRESS SHALL also exit to RESOLVE after any cycle where all latched b bits above bit[count] are 0.
REQ-026 Without ITER_MUL_EARLY_TERM_EN, COMPRESS SHALL always last exactly size cycles.
REQ-027 product SHALL be identical with and without the macro; only latency differs.

Verification
REQ-028 size=32, a=3, b=5, macro off -> done in cycle 34 only, product = 15, busy high cycles 1-33.
REQ-029 a=0xFFFFFFFF, b=0xFFFFFFFF -> product = 0xFFFFFFFE00000001 on done.
REQ-030 a=3, b=5 accepted, start with a=7, b=7 in cycle 10 -> ignored; product = 15; next start accepted in DONE cycle gives 49 at cycle 68.
REQ-031 Start a=2, b=2 (product 4 from prior run), kill in cycle 5 -> IDLE in cycle 6, busy 0, no done, product stays 4; reset in cycle 8 of a new op -> all outputs 0, no done.
REQ-032 Macro on: b=5 -> COMPRESS cycles 1-3, done in cycle 5, product = 5*a; b=0 -> done in cycle 3, product = 0.
